// File: rtl/red_and_pkg.sv
// Shared types and helpers for the streaming AND-reduction sequencer.
package red_and_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    RESP  = 1'b1
  } red_and_state_e;

  // Width of a counter that must hold 0..max_beats inclusive.
  function automatic int calc_cw(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/red_and_sequencer_red_and.sv
// Single-beat AND reduction used as the shared per-beat datapath.
module RedAnd #(
  parameter int width = 8
) (
  input  logic [width-1:0] in_i,
  output logic             z_o
);

  assign z_o = &in_i;

endmodule

// File: rtl/red_and_sequencer.sv
// Folds a multi-beat operand through one RedAnd and returns AND, beat count,
// first-zero index and overflow flag as one registered result per transaction.
module red_and_sequencer
  import red_and_pkg::*;
#(
  parameter int  width     = 8,
  parameter int  max_beats = 16,
  localparam int cw        = calc_cw(max_beats)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_z_o,
  output logic [cw-1:0]    out_beats_o,
  output logic             out_fz_valid_o,
  output logic [cw-1:0]    out_fz_idx_o,
  output logic             out_ovf_o
);

  localparam logic [cw-1:0] last_cnt_lp = cw'(max_beats - 1);

  red_and_state_e  state_q;
  logic            acc_q, acc_d;
  logic [cw-1:0]   cnt_q, cnt_d;
  logic            fz_seen_q, fz_seen_d;
  logic [cw-1:0]   fz_idx_q, fz_idx_d;

  logic            res_z_q;
  logic [cw-1:0]   res_beats_q;
  logic            res_fz_valid_q;
  logic [cw-1:0]   res_fz_idx_q;
  logic            res_ovf_q;

  logic            bz_s;
  logic            accept_s;
  logic            term_s;

  RedAnd #(.width(width)) u_red_and (
    .in_i (in_data_i),
    .z_o  (bz_s)
  );

  // Accumulator values as they would be after folding the current beat.
  always_comb begin
    accept_s  = in_valid_i && (state_q == ACCUM);
    acc_d     = acc_q & bz_s;
    cnt_d     = cnt_q + {{(cw-1){1'b0}}, 1'b1};
    fz_seen_d = fz_seen_q | ~bz_s;
    if (!bz_s && !fz_seen_q) begin
      fz_idx_d = cnt_q;
    end else begin
      fz_idx_d = fz_idx_q;
    end
    term_s = accept_s && (in_last_i || (cnt_q == last_cnt_lp));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ACCUM;
      acc_q          <= 1'b1;
      cnt_q          <= '0;
      fz_seen_q      <= 1'b0;
      fz_idx_q       <= '0;
      res_z_q        <= 1'b1;
      res_beats_q    <= '0;
      res_fz_valid_q <= 1'b0;
      res_fz_idx_q   <= '0;
      res_ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (term_s) begin
            res_z_q        <= acc_d;
            res_beats_q    <= cnt_d;
            res_fz_valid_q <= fz_seen_d;
            res_fz_idx_q   <= fz_idx_d;
            res_ovf_q      <= ~in_last_i;
            acc_q          <= 1'b1;
            cnt_q          <= '0;
            fz_seen_q      <= 1'b0;
            fz_idx_q       <= '0;
            state_q        <= RESP;
          end else if (accept_s) begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            fz_seen_q <= fz_seen_d;
            fz_idx_q  <= fz_idx_d;
          end else begin
            state_q <= ACCUM;
          end
        end
        RESP: begin
          // Result stays frozen until the consumer takes it.
          if (out_ready_i) begin
            state_q <= ACCUM;
          end else begin
            state_q <= RESP;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready_o     = (state_q == ACCUM);
  assign out_valid_o    = (state_q == RESP);
  assign out_z_o        = res_z_q;
  assign out_beats_o    = res_beats_q;
  assign out_fz_valid_o = res_fz_valid_q;
  assign out_fz_idx_o   = res_fz_idx_q;
  assign out_ovf_o      = res_ovf_q;

endmodule

// File: tb/tb_red_and_sequencer.sv
// Directed and randomized checks of red_and_sequencer with width=8, max_beats=4.
module tb_red_and_sequencer;

  localparam int W  = 8;
  localparam int MB = 4;
  localparam int CW = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [W-1:0]  in_data_i = '0;
  logic          in_last_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic          out_z_o;
  logic [CW-1:0] out_beats_o;
  logic          out_fz_valid_o;
  logic [CW-1:0] out_fz_idx_o;
  logic          out_ovf_o;

  int passed = 0;
  int total  = 0;

  red_and_sequencer #(.width(W), .max_beats(MB)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_data_i      (in_data_i),
    .in_last_i      (in_last_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_z_o        (out_z_o),
    .out_beats_o    (out_beats_o),
    .out_fz_valid_o (out_fz_valid_o),
    .out_fz_idx_o   (out_fz_idx_o),
    .out_ovf_o      (out_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [10:0] obs();
    return {out_valid_o, in_ready_o, out_z_o, out_beats_o, out_fz_valid_o, out_fz_idx_o, out_ovf_o};
  endfunction

  // Present one beat at a negedge; returns once accepted (ok=1) or after a bound.
  task automatic send_beat(input logic [W-1:0] d, input logic l, output bit ok);
    ok = 1'b0;
    in_valid_i = 1'b1; in_data_i = d; in_last_i = l;
    for (int i = 0; i < 20; i++) begin
      if (in_ready_o) begin
        @(posedge clk_i);
        ok = 1'b1;
        @(negedge clk_i);
        break;
      end
      @(negedge clk_i);
    end
    in_valid_i = 1'b0; in_last_i = 1'b0;
  endtask

  task automatic handshake();
    out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    total++; if (in_ready_o !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); else passed++;
    total++; if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); else passed++;
    total++; if ({out_z_o, out_beats_o, out_fz_valid_o, out_fz_idx_o, out_ovf_o} !== 9'b1_000_0_000_0)
      $display("FAIL reset_results got=%b exp=100000000", {out_z_o, out_beats_o, out_fz_valid_o, out_fz_idx_o, out_ovf_o});
    else passed++;
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_single();
    bit ok;
    send_beat(8'hFF, 1'b1, ok);
    total++; if (!ok) $display("FAIL single_accept got=timeout exp=accepted"); else passed++;
    // valid, !ready, z=1, beats=1, fzv=0, idx=0, ovf=0
    total++; if (obs() !== 11'b1_0_1_001_0_000_0) $display("FAIL single_result got=%b exp=%b", obs(), 11'b1_0_1_001_0_000_0); else passed++;
    handshake();
    total++; if ({out_valid_o, in_ready_o} !== 2'b01) $display("FAIL single_after_hs got=%b exp=01", {out_valid_o, in_ready_o}); else passed++;
  endtask

  task automatic test_first_zero();
    bit ok, a;
    ok = 1'b1;
    send_beat(8'hFF, 1'b0, a); ok &= a;
    send_beat(8'hFE, 1'b0, a); ok &= a;
    send_beat(8'h00, 1'b1, a); ok &= a;
    total++; if (!ok) $display("FAIL fz_accept got=timeout exp=accepted"); else passed++;
    total++; if (obs() !== 11'b1_0_0_011_1_001_0) $display("FAIL fz_result got=%b exp=%b", obs(), 11'b1_0_0_011_1_001_0); else passed++;
    handshake();
  endtask

  task automatic test_overflow();
    bit ok, a;
    bit stalled_ok;
    ok = 1'b1;
    for (int i = 0; i < MB; i++) begin
      send_beat(8'hFF, 1'b0, a); ok &= a;
    end
    total++; if (!ok) $display("FAIL ovf_accept got=timeout exp=accepted"); else passed++;
    total++; if (obs() !== 11'b1_0_1_100_0_000_1) $display("FAIL ovf_result got=%b exp=%b", obs(), 11'b1_0_1_100_0_000_1); else passed++;
    // Fifth beat waits while the overflow result is pending.
    in_valid_i = 1'b1; in_data_i = 8'h00; in_last_i = 1'b1;
    stalled_ok = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) stalled_ok = 1'b0;
    end
    total++; if (!stalled_ok) $display("FAIL ovf_stall got=accepted_or_dropped exp=stalled"); else passed++;
    out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    out_ready_i = 1'b0;
    total++; if ({out_valid_o, in_ready_o} !== 2'b01) $display("FAIL ovf_release got=%b exp=01", {out_valid_o, in_ready_o}); else passed++;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0; in_last_i = 1'b0;
    total++; if (obs() !== 11'b1_0_0_001_1_000_0) $display("FAIL ovf_fifth got=%b exp=%b", obs(), 11'b1_0_0_001_1_000_0); else passed++;
    handshake();
  endtask

  task automatic test_back_to_back();
    bit ok, a;
    bit stable_ok;
    bit comb_ok;
    logic [10:0] snap;
    ok = 1'b1;
    send_beat(8'hFF, 1'b0, a); ok &= a;
    // Wiggle inputs mid-cycle in ACCUM; no output may follow them.
    snap = obs();
    in_valid_i = 1'b1; in_data_i = 8'h00; in_last_i = 1'b1; out_ready_i = 1'b1;
    #1;
    comb_ok = (obs() === snap);
    in_valid_i = 1'b0; in_data_i = 8'hFF; in_last_i = 1'b0; out_ready_i = 1'b0;
    #1;
    send_beat(8'hFF, 1'b1, a); ok &= a;
    total++; if (!ok) $display("FAIL bp_accept got=timeout exp=accepted"); else passed++;
    in_valid_i = 1'b1; in_data_i = 8'h0F; in_last_i = 1'b1;
    stable_ok = 1'b1;
    repeat (5) begin
      if (obs() !== 11'b1_0_1_010_0_000_0) stable_ok = 1'b0;
      @(negedge clk_i);
    end
    total++; if (!stable_ok) $display("FAIL bp_stable got=%b exp=%b", obs(), 11'b1_0_1_010_0_000_0); else passed++;
    // Wiggle data mid-cycle in RESP as well.
    snap = obs();
    in_data_i = 8'hA5; in_last_i = 1'b0;
    #1;
    if (obs() !== snap) comb_ok = 1'b0;
    in_data_i = 8'h0F; in_last_i = 1'b1;
    #1;
    total++; if (!comb_ok) $display("FAIL comb_path got=output_followed_input exp=registered_only"); else passed++;
    out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    out_ready_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0; in_last_i = 1'b0;
    total++; if (obs() !== 11'b1_0_0_001_1_000_0) $display("FAIL bp_next got=%b exp=%b", obs(), 11'b1_0_0_001_1_000_0); else passed++;
    handshake();
  endtask

  task automatic test_async_reset();
    bit ok, a;
    ok = 1'b1;
    send_beat(8'hFF, 1'b0, a); ok &= a;
    send_beat(8'hFF, 1'b0, a); ok &= a;
    #2 rst_ni = 1'b0;
    #1;
    total++; if ({in_ready_o, out_valid_o, out_beats_o} !== 5'b10_000)
      $display("FAIL arst_mid got=%b exp=10000", {in_ready_o, out_valid_o, out_beats_o});
    else passed++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    send_beat(8'h7F, 1'b1, a); ok &= a;
    total++; if (!ok) $display("FAIL arst_accept got=timeout exp=accepted"); else passed++;
    total++; if (obs() !== 11'b1_0_0_001_1_000_0) $display("FAIL arst_next got=%b exp=%b", obs(), 11'b1_0_0_001_1_000_0); else passed++;
    // Reset while a result is pending discards it.
    #2 rst_ni = 1'b0;
    #1;
    total++; if (obs() !== 11'b0_1_1_000_0_000_0) $display("FAIL arst_resp got=%b exp=%b", obs(), 11'b0_1_1_000_0_000_0); else passed++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_random();
    bit ok, a;
    bit stall_ok;
    int len, dly;
    bit use_last;
    logic [W-1:0] d;
    logic         e_z, e_fzv;
    logic [CW-1:0] e_idx;
    logic [10:0]  e;
    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(1, MB);
      use_last = (len < MB) ? 1'b1 : 1'($urandom_range(0, 1));
      e_z = 1'b1; e_fzv = 1'b0; e_idx = '0; ok = 1'b1;
      for (int b = 0; b < len; b++) begin
        d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
        if (d != 8'hFF) begin
          if (!e_fzv) e_idx = CW'(b);
          e_fzv = 1'b1;
          e_z = 1'b0;
        end
        send_beat(d, use_last && (b == len - 1), a); ok &= a;
      end
      e = {1'b1, 1'b0, e_z, CW'(len), e_fzv, e_idx, ~use_last};
      total++; if (!ok) $display("FAIL rand_accept t=%0d got=timeout exp=accepted", t); else passed++;
      dly = $urandom_range(0, 3);
      stall_ok = 1'b1;
      for (int s = 0; s <= dly; s++) begin
        if (obs() !== e) stall_ok = 1'b0;
        if (s < dly) @(negedge clk_i);
      end
      total++; if (!stall_ok) $display("FAIL rand_result t=%0d got=%b exp=%b", t, obs(), e); else passed++;
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_first_zero();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
